// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
package pipeline_ctrl_types;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_BUSY = 2'd1,
    EX_DONE = 2'd2
  } pipeline_ctrl_state_t;

  // Bundle of every combinational control output, so one assignment sets them all.
  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic idex_load;
    logic exmem_load;
    logic memwb_load;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic muldiv_start;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;
  // Free-running pipeline: every stage register loads, nothing is flushed.
  localparam ctrl_t CTRL_RUN  = '{pc_load: 1'b1, ifid_load: 1'b1, idex_load: 1'b1,
                                  exmem_load: 1'b1, memwb_load: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                count <= '0;
    else if (inc && ~&count) count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory stalls, load-use bubbles,
// branch redirects and the multi-cycle mul/div handshake.
module pipeline_ctrl
  import pipeline_ctrl_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_rs1_used,
  input  logic             ifid_rs2_used,
  input  logic             idex_is_load,
  input  logic [4:0]       idex_rd,
  input  logic             idex_is_muldiv,
  input  logic             muldiv_done,
  input  logic             ex_redirect,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             muldiv_start,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  pipeline_ctrl_state_t state, nxt;
  ctrl_t                c;
  logic                 mem_stall, load_use, bubble_inc, stall_inc;

  assign mem_stall = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
  assign load_use  = idex_is_load & (idex_rd != 5'd0) &
                     ((ifid_rs1_used & (ifid_rs1 == idex_rd)) |
                      (ifid_rs2_used & (ifid_rs2 == idex_rd)));

  // State register; reset abandons any in-flight mul/div.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= nxt;
  end

  // Next state and stage controls. Memory stall freezes everything; in RUN a
  // redirect beats mul/div, which beats a load-use bubble.
  always_comb begin
    nxt        = state;
    c          = CTRL_NONE;
    bubble_inc = 1'b0;
    case (state)
      RUN: if (!mem_stall) begin
        if (ex_redirect) begin
          c            = CTRL_RUN;
          c.ifid_flush = 1'b1;
          c.idex_flush = 1'b1;
        end else if (idex_is_muldiv) begin
          c.muldiv_start = 1'b1;
          c.exmem_load   = 1'b1;
          c.exmem_flush  = 1'b1;
          c.memwb_load   = 1'b1;
          nxt            = EX_BUSY;
        end else if (load_use) begin
          c            = CTRL_RUN;
          c.pc_load    = 1'b0;
          c.ifid_load  = 1'b0;
          c.idex_flush = 1'b1;
          bubble_inc   = 1'b1;
        end else begin
          c = CTRL_RUN;
        end
      end
      EX_BUSY: begin
        if (muldiv_done) nxt = mem_stall ? EX_DONE : RUN;
        if (!mem_stall) begin
          // On the done cycle the result moves EX->MEM like a normal cycle.
          if (muldiv_done) c = CTRL_RUN;
          else begin
            c.exmem_load  = 1'b1;
            c.exmem_flush = 1'b1;
            c.memwb_load  = 1'b1;
          end
        end
      end
      EX_DONE: if (!mem_stall) begin
        c   = CTRL_RUN;
        nxt = RUN;
      end
      default: nxt = RUN;
    endcase
    // Outputs must drop the instant reset asserts, not at the next edge.
    if (!rst) c = CTRL_NONE;
  end

  assign stall_inc = mem_stall | (state != RUN);

  assign pc_load      = c.pc_load;
  assign ifid_load    = c.ifid_load;
  assign idex_load    = c.idex_load;
  assign exmem_load   = c.exmem_load;
  assign memwb_load   = c.memwb_load;
  assign ifid_flush   = c.ifid_flush;
  assign idex_flush   = c.idex_flush;
  assign exmem_flush  = c.exmem_flush;
  assign muldiv_start = c.muldiv_start;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(bubble_inc), .count(bubble_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_rs1_used, ifid_rs2_used, idex_is_load, idex_is_muldiv;
  logic        muldiv_done, ex_redirect;
  logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic        pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic        ifid_flush, idex_flush, exmem_flush, muldiv_start;
  logic [31:0] stall_cycles, bubble_count;

  int tests  = 0;
  int failed = 0;
  int starts = 0;

  // {pc, ifid, idex, exmem, memwb loads, ifid/idex/exmem flushes, start}
  logic [8:0] ctl;
  assign ctl = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                ifid_flush, idex_flush, exmem_flush, muldiv_start};

  localparam logic [8:0] C_ZERO  = 9'h000;
  localparam logic [8:0] C_RUN   = 9'h1F0;
  localparam logic [8:0] C_REDIR = 9'h1FC;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .idex_is_load(idex_is_load), .idex_rd(idex_rd),
    .idex_is_muldiv(idex_is_muldiv), .muldiv_done(muldiv_done),
    .ex_redirect(ex_redirect),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .muldiv_start(muldiv_start),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  task automatic idle();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_rs1_used = 0; ifid_rs2_used = 0;
    idex_is_load = 0; idex_rd = 5'd0; idex_is_muldiv = 0; muldiv_done = 0;
    ex_redirect = 0; imem_read = 0; imem_resp = 0;
    dmem_read = 0; dmem_write = 0; dmem_resp = 0;
  endtask

  task automatic step();
    if (muldiv_start) starts++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    #3;
    tests++; if (ctl !== C_ZERO) begin failed++; $display("FAIL reset_ctl got %h want %h", ctl, C_ZERO); end
    tests++; if (stall_cycles !== 0 || bubble_count !== 0) begin failed++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, bubble_count); end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL run_idle got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (stall_cycles !== 0) begin failed++; $display("FAIL idle_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    idle(); idex_is_load = 1; idex_rd = 5'd5; ifid_rs1 = 5'd3; ifid_rs1_used = 1;
    ifid_rs2 = 5'd5; ifid_rs2_used = 1; #1;
    tests++; if ({pc_load, ifid_load, idex_flush, exmem_load, memwb_load, muldiv_start} !== 6'b001110) begin
      failed++; $display("FAIL load_use_ctl got %h", ctl); end
    tests++; if (bubble_count !== 0) begin failed++; $display("FAIL bubble_pre got %0d want 0", bubble_count); end
    step();
    tests++; if (bubble_count !== 1) begin failed++; $display("FAIL bubble_post got %0d want 1", bubble_count); end
    idle(); #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL after_bubble got %h want %h", ctl, C_RUN); end
    step();
  endtask

  task automatic test_load_rd0();
    idle(); idex_is_load = 1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs1_used = 1; #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL rd0_ctl got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (bubble_count !== 1) begin failed++; $display("FAIL rd0_bubble got %0d want 1", bubble_count); end
  endtask

  task automatic test_redirect();
    idle(); idex_is_load = 1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs1_used = 1;
    ex_redirect = 1; #1;
    tests++; if (ctl !== C_REDIR) begin failed++; $display("FAIL redirect_ctl got %h want %h", ctl, C_REDIR); end
    step();
    tests++; if (bubble_count !== 1) begin failed++; $display("FAIL redirect_bubble got %0d want 1", bubble_count); end
  endtask

  task automatic test_muldiv();
    idle(); idex_is_muldiv = 1; starts = 0; #1;
    tests++; if ({pc_load, ifid_load, idex_load, exmem_flush, memwb_load, muldiv_start} !== 6'b000111) begin
      failed++; $display("FAIL md_start got %h", ctl); end
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({pc_load, ifid_load, idex_load, exmem_flush, memwb_load, muldiv_start} !== 6'b000110) begin
        failed++; $display("FAIL md_busy%0d got %h", i, ctl); end
      step();
    end
    muldiv_done = 1; #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL md_done got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (stall_cycles !== 4) begin failed++; $display("FAIL md_stall got %0d want 4", stall_cycles); end
    idle(); #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL md_after got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (starts !== 1) begin failed++; $display("FAIL md_starts got %0d want 1", starts); end
  endtask

  task automatic test_muldiv_memstall();
    idle(); idex_is_muldiv = 1; starts = 0; #1;
    step();
    step();
    muldiv_done = 1; dmem_read = 1; #1;
    tests++; if (ctl !== C_ZERO) begin failed++; $display("FAIL mds_done got %h want 0", ctl); end
    step();
    muldiv_done = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (ctl !== C_ZERO) begin failed++; $display("FAIL mds_hold%0d got %h want 0", i, ctl); end
      step();
    end
    tests++; if (stall_cycles !== 8) begin failed++; $display("FAIL mds_stall got %0d want 8", stall_cycles); end
    dmem_resp = 1; #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL mds_adv got %h want %h", ctl, C_RUN); end
    step();
    idle(); #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL mds_run got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (stall_cycles !== 9 || starts !== 1) begin failed++;
      $display("FAIL mds_final got %0d/%0d want 9/1", stall_cycles, starts); end
  endtask

  task automatic test_imem_stall();
    idle(); imem_read = 1; #1;
    tests++; if (ctl !== C_ZERO) begin failed++; $display("FAIL imem_stall got %h want 0", ctl); end
    step();
    imem_resp = 1; #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL imem_resp got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (stall_cycles !== 10) begin failed++; $display("FAIL imem_cnt got %0d want 10", stall_cycles); end
  endtask

  task automatic test_reset_mid_busy();
    idle(); idex_is_muldiv = 1; #1;
    step();
    #1;
    tests++; if (exmem_flush !== 1'b1) begin failed++; $display("FAIL rb_busy got %h", ctl); end
    #1; rst = 1'b0; #1;
    tests++; if (ctl !== C_ZERO || stall_cycles !== 0 || bubble_count !== 0) begin failed++;
      $display("FAIL rb_async got %h %0d %0d want 0 0 0", ctl, stall_cycles, bubble_count); end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    tests++; if (muldiv_start !== 1'b1) begin failed++; $display("FAIL rb_restart got %b want 1", muldiv_start); end
    step();
    muldiv_done = 1; #1;
    tests++; if (ctl !== C_RUN) begin failed++; $display("FAIL rb_done got %h want %h", ctl, C_RUN); end
    step();
    tests++; if (stall_cycles !== 1) begin failed++; $display("FAIL rb_stall got %0d want 1", stall_cycles); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_rd0();
    test_redirect();
    test_muldiv();
    test_muldiv_memstall();
    test_imem_stall();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ifid_rs1, ifid_rs2  in  5 each  source registers of instruction in ID.
REQ-005 SHALL have ports ifid_rs1_used, ifid_rs2_used  in  1 each  ID instruction reads rs1/rs2.
REQ-006 SHALL have ports idex_is_load  in  1 and idex_rd  in  5  EX instruction is a load, its destination.
REQ-007 SHALL have port idex_is_muldiv  in  1  EX instruction needs the multi-cycle mul/div unit.
REQ-008 SHALL have port muldiv_done  in  1  one-cycle pulse, mul/div result valid.
REQ-009 SHALL have port ex_redirect  in  1  taken branch/jump resolved in EX.
REQ-010 SHALL have ports imem_read, imem_resp, dmem_read, dmem_write, dmem_resp  in  1 each  cache handshakes.
REQ-011 SHALL have ports pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1 each  stage register enables.
REQ-012 SHALL have ports ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP) into that stage register.
REQ-013 SHALL have port muldiv_start  out  1  one-cycle start pulse to mul/div unit.
REQ-014 SHALL have ports stall_cycles, bubble_count  out  CNT_W each  performance counters.

Function
REQ-015 mem_stall SHALL equal (imem_read & ~imem_resp) | ((dmem_read|dmem_write) & ~dmem_resp).
REQ-016 FSM states SHALL be RUN, EX_BUSY, EX_DONE.
REQ-017 mem_stall SHALL have top priority in every state: all loads 0, all flushes 0, muldiv_start 0, FSM holds except as REQ-021.
REQ-018 RUN, no mem_stall, no other event: all five loads 1, flushes 0.
REQ-019 RUN, ex_redirect, no mem_stall: all loads 1, ifid_flush=1, idex_flush=1; redirect SHALL win over load-use and muldiv.
REQ-020 RUN, idex_is_muldiv, no redirect, no mem_stall: muldiv_start=1 for exactly one cycle, go EX_BUSY; pc/ifid/idex loads 0, exmem_flush=1, memwb_load=1.
REQ-021 EX_BUSY: pc/ifid/idex loads 0, exmem_flush=1, memwb_load=~mem_stall; muldiv_done -> RUN if no mem_stall that cycle, else EX_DONE (done latched).
REQ-022 EX_DONE: hold all loads 0 while mem_stall; first cycle without mem_stall behave as REQ-018 and go RUN; muldiv_start SHALL NOT re-fire.
REQ-023 The muldiv instruction advancing EX->MEM on the RUN return cycle SHALL NOT trigger muldiv_start (next EX instruction is evaluated on the following cycle).
REQ-024 Load-use hazard = idex_is_load & idex_rd!=0 & ((ifid_rs1_used & ifid_rs1==idex_rd) | (ifid_rs2_used & ifid_rs2==idex_rd)).
REQ-025 RUN, load-use, no redirect, no mem_stall: pc_load=0, ifid_load=0, idex_flush=1, exmem/memwb loads 1; exactly one bubble.
REQ-026 stall_cycles SHALL increment every cycle mem_stall=1 or state!=RUN; saturate at all-ones.
REQ-027 bubble_count SHALL increment once per load-use bubble (REQ-025); saturate at all-ones.
REQ-028 Outputs other than counters SHALL be combinational from state and inputs; counters registered.

Reset
REQ-029 rst=0 SHALL immediately force state RUN, counters 0, all loads/flushes/muldiv_start 0, regardless of clk.
REQ-030 Reset mid-EX_BUSY SHALL abandon the op; after release a muldiv in EX SHALL be started anew.

Structure
REQ-031 State enum pipeline_ctrl_state_t SHALL live in package pipeline_ctrl_types.
REQ-032 One sub-module sat_counter (parameter width, inc in, count out, async active-low reset) SHALL implement both counters.

Verification
REQ-033 Load-use: idex_is_load=1, idex_rd=5, ifid_rs2=5 used -> one cycle pc_load=0, idex_flush=1; bubble_count 0->1.
REQ-034 Load with idex_rd=0, ifid_rs1=0 used -> no stall, bubble_count unchanged.
REQ-035 Muldiv, done after 4 cycles -> single muldiv_start, 4 stall cycles with exmem_flush=1, RUN on done cycle; stall_cycles=4.
REQ-036 muldiv_done while dmem_read=1, dmem_resp=0 for 3 cycles -> EX_DONE, loads 0, advance on dmem_resp, no second start.
REQ-037 ex_redirect with concurrent load-use -> ifid_flush=idex_flush=1, pc_load=1, bubble_count unchanged.
REQ-038 rst=0 asserted mid-EX_BUSY between clock edges -> outputs 0 immediately, counters 0, state RUN.
